// File: rtl/fact_pkg.sv
// Shared definitions for the factorial sequencer slice.
// State codes, datapath select codes and the default iteration guard.
package fact_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_INIT  = 3'd1;
  localparam state_t ST_CHECK = 3'd2;
  localparam state_t ST_MUL   = 3'd3;
  localparam state_t ST_DEC   = 3'd4;
  localparam state_t ST_DONE  = 3'd5;

  localparam logic [1:0] SEL_A_HOLD = 2'b00;
  localparam logic [1:0] SEL_A_MUL  = 2'b01;
  localparam logic [1:0] SEL_A_ONE  = 2'b10;

  localparam logic [1:0] SEL_B_HOLD = 2'b00;
  localparam logic [1:0] SEL_B_DEC  = 2'b01;
  localparam logic [1:0] SEL_B_LOAD = 2'b10;

  localparam int MAX_ITER_DEF = 20;

endpackage

// File: rtl/fact_if.sv
// Host/datapath bundle of the factorial sequencer.
// master = host + datapath side, slave = sequencer side.
interface fact_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             z;
  logic             ovf;
  logic [1:0]       WAsel;
  logic [1:0]       WBsel;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] iter_cnt;

  modport master (
    output start, z, ovf,
    input  WAsel, WBsel, busy,
    input  done, err, iter_cnt
  );

  modport slave (
    input  start, z, ovf,
    output WAsel, WBsel, busy,
    output done, err, iter_cnt
  );
endinterface

// File: rtl/fact_iter_cnt.sv
// Saturating MUL-iteration counter with clear
// and the iteration-guard compare.
module fact_iter_cnt
  import fact_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int MAX_ITER = MAX_ITER_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             at_max
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_max = (cnt == CNT_W'(MAX_ITER));

endmodule

// File: rtl/fact_seq_ctrl.sv
// Registered sequencer for the factorial datapath.
// Optional FACT_OVF_ABORT_EN: abort a run on multiplier overflow.
module fact_seq_ctrl
  import fact_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int MAX_ITER = MAX_ITER_DEF
) (
  input  logic clk,
  input  logic reset,
  fact_if.slave bus
);

  state_t     state;
  state_t     state_nxt;
  logic       err_set;
  logic       at_max;
  logic       cnt_clr;
  logic       cnt_inc;
  logic [1:0] wa_nxt;
  logic [1:0] wb_nxt;

  assign cnt_clr = (state == ST_IDLE) && bus.start;
  assign cnt_inc = (state == ST_MUL);

  fact_iter_cnt #(
    .CNT_W   (CNT_W),
    .MAX_ITER(MAX_ITER)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .cnt   (bus.iter_cnt),
    .at_max(at_max)
  );

`ifndef FACT_OVF_ABORT_EN
  logic ovf_unused;
  assign ovf_unused = bus.ovf;
`endif

  always_comb begin
    state_nxt = state;
    err_set   = 1'b0;
    unique case (state)
      ST_IDLE:  if (bus.start) state_nxt = ST_INIT;
      ST_INIT:  state_nxt = ST_CHECK;
      ST_CHECK: begin
        if (bus.z) begin
          state_nxt = ST_DONE;
        end else if (at_max) begin
          state_nxt = ST_DONE;
          err_set   = 1'b1;
        end else begin
          state_nxt = ST_MUL;
        end
      end
`ifdef FACT_OVF_ABORT_EN
      ST_MUL: begin
        if (bus.ovf) begin
          state_nxt = ST_DONE;
          err_set   = 1'b1;
        end else begin
          state_nxt = ST_DEC;
        end
      end
`else
      ST_MUL:   state_nxt = ST_DEC;
`endif
      ST_DEC:   state_nxt = ST_CHECK;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Selects are decoded from the next state so they register with it.
  always_comb begin
    wa_nxt = SEL_A_HOLD;
    wb_nxt = SEL_B_HOLD;
    unique case (1'b1)
      (state_nxt == ST_INIT): begin
        wa_nxt = SEL_A_ONE;
        wb_nxt = SEL_B_LOAD;
      end
      (state_nxt == ST_MUL): wa_nxt = SEL_A_MUL;
      (state_nxt == ST_DEC): wb_nxt = SEL_B_DEC;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      bus.WAsel <= SEL_A_HOLD;
      bus.WBsel <= SEL_B_HOLD;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      bus.WAsel <= wa_nxt;
      bus.WBsel <= wb_nxt;
      bus.busy  <= (state_nxt != ST_IDLE);
      bus.done  <= (state_nxt == ST_DONE);
      if (cnt_clr) begin
        bus.err <= 1'b0;
      end else if (err_set) begin
        bus.err <= 1'b1;
      end
    end
  end

endmodule
